// File: rtl/control_sequencer_if.sv
// Fetch handshake and table-programming bus for control_sequencer.
interface control_sequencer_if #(
  parameter int INST_W = 5,
  parameter int PA_W   = 6,
  parameter int CS_W   = 16
);
  logic [INST_W-1:0] inst;
  logic              inst_valid;
  logic              inst_ready;
  logic              prog_we;
  logic              prog_sel;
  logic [PA_W-1:0]   prog_addr;
  logic [CS_W-1:0]   prog_data;

  modport master (
    output inst, inst_valid,
    output prog_we, prog_sel,
    output prog_addr, prog_data,
    input  inst_ready
  );

  modport slave (
    input  inst, inst_valid,
    input  prog_we, prog_sel,
    input  prog_addr, prog_data,
    output inst_ready
  );
endinterface

// File: rtl/control_sequencer.sv
// Microcoded control sequencer: metadata + microcode tables, FETCH/EXEC FSM.
// Define CTRL_SEQ_ILLEGAL_EN to enable illegal-instruction detection.
module control_sequencer #(
  parameter int INST_W = 5,
  parameter int OP_W   = 4,
  parameter int STEP_W = 2,
  parameter int CS_W   = 16,
  localparam int MW    = OP_W + STEP_W,
  localparam int PA_W  = (INST_W > MW) ? INST_W : MW
) (
  input  logic               clk,
  input  logic               reset,
  control_sequencer_if.slave bus,
  input  logic               stall,
  output logic [CS_W-1:0]    control_signals,
  output logic               busy,
  output logic [STEP_W-1:0]  step,
  output logic               illegal
);

`ifdef CTRL_SEQ_ILLEGAL_EN
  localparam int MD_W = MW + 1;
`else
  localparam int MD_W = MW;
`endif

  typedef enum logic {FETCH, EXEC} state_t;

  logic [MD_W-1:0] meta  [2**INST_W];
  logic [CS_W-1:0] ucode [2**MW];

  state_t            state, eff, state_n;
  logic [STEP_W-1:0] step_q, step_n;
  logic [STEP_W-1:0] last_q, last_n;
  logic [OP_W-1:0]   op_q, op_n;
  logic              ill_q, ill_n;
  logic [MD_W-1:0]   meta_rd;
  logic              accept;
  logic              legal;
  logic              unused_bits;

  assign unused_bits = ^{bus.prog_addr, bus.prog_data};

  // Tables are never reset; reads below see the pre-write value.
  always_ff @(posedge clk) begin
    if (bus.prog_we) begin
      if (bus.prog_sel)
        ucode[bus.prog_addr[MW-1:0]] <= bus.prog_data;
      else
        meta[bus.prog_addr[INST_W-1:0]] <= bus.prog_data[MD_W-1:0];
    end
  end

  assign meta_rd = meta[bus.inst];
`ifdef CTRL_SEQ_ILLEGAL_EN
  assign legal = meta_rd[MW];
`else
  assign legal = 1'b1;
`endif

  // Reset makes the outputs look like FETCH within the reset cycle.
  assign eff    = reset ? FETCH : state;
  assign accept = (eff == FETCH) && bus.inst_valid && !stall;

  always_comb begin
    state_n         = state;
    step_n          = step_q;
    op_n            = op_q;
    last_n          = last_q;
    ill_n           = 1'b0;
    control_signals = '0;
    unique case (eff)
      FETCH: begin
        if (accept && legal) begin
          control_signals = ucode[{MW{1'b0}}];
          state_n         = EXEC;
          op_n            = meta_rd[OP_W-1:0];
          last_n          = meta_rd[MW-1:OP_W];
          step_n          = '0;
        end else if (accept) begin
          ill_n = 1'b1;
        end
      end
      EXEC: begin
        if (!stall) begin
          control_signals = ucode[{op_q, step_q}];
          if (step_q == last_q) begin
            state_n = FETCH;
            step_n  = '0;
          end else begin
            step_n = step_q + STEP_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= FETCH;
      step_q <= '0;
      op_q   <= '0;
      last_q <= '0;
      ill_q  <= 1'b0;
    end else begin
      state  <= state_n;
      step_q <= step_n;
      op_q   <= op_n;
      last_q <= last_n;
      ill_q  <= ill_n;
    end
  end

  assign bus.inst_ready = (eff == FETCH);
  assign busy           = (eff == EXEC);
  assign step           = (eff == EXEC) ? step_q : '0;
  assign illegal        = ill_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized bench for control_sequencer against a behavioural model.
// Covers the programmed sequence, stalls, reset, table-write timing, illegal.
module tb_control_sequencer;
  localparam int INST_W = 5;
  localparam int OP_W   = 4;
  localparam int STEP_W = 2;
  localparam int CS_W   = 16;
  localparam int PA_W   = 6;
  localparam int NSTEP  = 1 << STEP_W;

  logic clk = 1'b0;
  logic reset;
  logic stall;
  logic [CS_W-1:0]   control_signals;
  logic              busy;
  logic [STEP_W-1:0] step;
  logic              illegal;

  control_sequencer_if #(.INST_W(INST_W), .PA_W(PA_W), .CS_W(CS_W)) bus ();

  control_sequencer #(
    .INST_W(INST_W), .OP_W(OP_W), .STEP_W(STEP_W), .CS_W(CS_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .stall(stall),
    .control_signals(control_signals),
    .busy(busy),
    .step(step),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_mis = 0;

  logic [6:0]  m_meta [32];
  logic [15:0] m_uc   [64];
  bit m_busy = 0;
  bit m_ill  = 0;
  int m_op   = 0;
  int m_len  = 0;
  int m_k    = 0;

  logic [15:0] obs_cs;
  logic        obs_rdy, obs_busy, obs_ill;
  logic [1:0]  obs_step;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit is_legal(input int i);
`ifdef CTRL_SEQ_ILLEGAL_EN
    return m_meta[i][6];
`else
    return 1'b1;
`endif
  endfunction

  // One clock: drive, check against the model, then advance the model.
  task automatic cyc(input bit rst, input bit iv, input int in,
                     input bit st, input bit we, input bit sel,
                     input int addr, input logic [15:0] data);
    bit run, acc, lg;
    logic [15:0] e_cs;
    @(negedge clk);
    reset          = rst;
    bus.inst_valid = iv;
    bus.inst       = INST_W'(in);
    stall          = st;
    bus.prog_we    = we;
    bus.prog_sel   = sel;
    bus.prog_addr  = PA_W'(addr);
    bus.prog_data  = data;
    #1;
    obs_cs   = control_signals;
    obs_rdy  = bus.inst_ready;
    obs_busy = busy;
    obs_step = step;
    obs_ill  = illegal;
    run = !rst && m_busy;
    acc = !run && iv && !st;
    lg  = is_legal(in);
    if (run && !st) e_cs = m_uc[m_op * NSTEP + m_k];
    else if (acc && lg) e_cs = m_uc[0];
    else e_cs = 16'h0;
    chk("cs", 32'(obs_cs), 32'(e_cs));
    chk("ready", 32'(obs_rdy), 32'(!run));
    chk("busy", 32'(obs_busy), 32'(run));
    chk("step", 32'(obs_step), run ? m_k : 0);
    chk("illegal", 32'(obs_ill), 32'(m_ill));
    if (rst) begin
      m_busy = 0;
      m_k    = 0;
      m_ill  = 0;
    end else begin
      m_ill = acc && !lg;
      if (run && !st) begin
        m_k++;
        if (m_k == m_len) begin
          m_busy = 0;
          m_k    = 0;
        end
      end else if (acc && lg) begin
        m_busy = 1;
        m_op   = int'(m_meta[in][3:0]);
        m_len  = int'(m_meta[in][5:4]) + 1;
        m_k    = 0;
      end
    end
    if (we) begin
      if (sel) m_uc[addr % 64] = data;
      else m_meta[addr % 32] = data[6:0];
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 16'h0);
  endtask

  task automatic wr(input bit sel, input int addr, input logic [15:0] d);
    cyc(0, 0, 0, 0, 1, sel, addr, d);
  endtask

  task automatic fetch(input int in);
    cyc(0, 1, in, 0, 0, 0, 0, 16'h0);
  endtask

  initial begin
    logic [15:0] d;
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0, 0, 16'h0);
    for (int i = 0; i < 64; i++) wr(1, i, 16'($urandom));
    for (int i = 0; i < 32; i++) wr(0, i, 16'($urandom_range(0, 63) | 64));
    wr(1, 0, 16'h0001);
    wr(1, 20, 16'h0A01);
    wr(1, 21, 16'h0A02);
    wr(1, 22, 16'h0A03);
    wr(0, 3, 16'h0065);
    wr(0, 7, 16'h0012);

    fetch(3);
    chk("seq_w0", 32'(obs_cs), 32'h0001);
    idle(1);
    chk("seq_w1", 32'(obs_cs), 32'h0A01);
    idle(1);
    chk("seq_w2", 32'(obs_cs), 32'h0A02);
    idle(1);
    chk("seq_w3", 32'(obs_cs), 32'h0A03);
    idle(1);
    chk("seq_rdy", 32'(obs_rdy), 32'h1);

    fetch(3);
    idle(1);
    for (int i = 0; i < 2; i++) begin
      cyc(0, 0, 0, 1, 0, 0, 0, 16'h0);
      chk("stall_cs", 32'(obs_cs), 32'h0);
      chk("stall_step", 32'(obs_step), 32'h1);
    end
    idle(1);
    chk("resume_w2", 32'(obs_cs), 32'h0A02);
    idle(1);
    chk("resume_w3", 32'(obs_cs), 32'h0A03);

    fetch(3);
    idle(1);
    cyc(1, 0, 0, 0, 0, 0, 0, 16'h0);
    idle(1);
    chk("rst_busy", 32'(obs_busy), 32'h0);
    chk("rst_rdy", 32'(obs_rdy), 32'h1);
    fetch(3);
    idle(1);
    chk("restart_step", 32'(obs_step), 32'h0);
    chk("restart_w1", 32'(obs_cs), 32'h0A01);
    idle(2);

    idle(3);
    chk("idle_cs", 32'(obs_cs), 32'h0);

    fetch(3);
    cyc(0, 0, 0, 0, 1, 1, 21, 16'hBEEF);
    idle(1);
    chk("wr_next", 32'(obs_cs), 32'hBEEF);
    cyc(0, 0, 0, 0, 1, 1, 22, 16'h1234);
    chk("wr_same", 32'(obs_cs), 32'h0A03);

    fetch(7);
`ifdef CTRL_SEQ_ILLEGAL_EN
    chk("ill_cs", 32'(obs_cs), 32'h0);
    idle(1);
    chk("ill_pulse", 32'(obs_ill), 32'h1);
    chk("ill_busy", 32'(obs_busy), 32'h0);
    idle(1);
    chk("ill_clear", 32'(obs_ill), 32'h0);
`else
    chk("i7_cs", 32'(obs_cs), 32'h0001);
    idle(1);
    chk("i7_busy", 32'(obs_busy), 32'h1);
    chk("i7_ill", 32'(obs_ill), 32'h0);
`endif
    idle(3);

    for (int i = 0; i < 600; i++) begin
      d = 16'($urandom);
      if ($urandom_range(0, 3) != 0) d[6] = 1'b1;
      cyc($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0,
          int'($urandom_range(0, 31)), $urandom_range(0, 4) == 0,
          $urandom_range(0, 5) == 0, 1'($urandom),
          int'($urandom_range(0, 63)), d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
